posit_div: RTL

Sequential posit<32,3> divider and the inverse-operation companion to the posit multiplier. It accepts two posit operands on a start pulse and decodes both internally. It subtracts the scales, divides the mantissas with a one-bit-per-cycle restoring loop, and rounds and re-encodes the quotient to a posit. It sits beside the multiplier in the arithmetic datapath and uses the same start/done handshake.

---
 rtl/posit_pkg.sv | 25 ++
 rtl/posit_field_decode.sv | 41 ++++
 rtl/posit_div.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared constants and types for the posit<32,3> arithmetic datapath.
package posit_pkg;

  localparam int N  = 32;
  localparam int ES = 3;
  localparam int MW = 30;

  localparam logic [N-1:0] NAR    = 32'h8000_0000;
  localparam logic [N-1:0] MAXPOS = 32'h7FFF_FFFF;
  localparam logic [N-1:0] MINPOS = 32'h0000_0001;

  typedef logic signed [9:0] scale_t;

  localparam scale_t SCALE_MAX = 10'sd240;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    DIVIDE,
    NORM,
    ENCODE,
    DONE
  } state_e;

endpackage

// File: rtl/posit_field_decode.sv
// Combinational posit<32,3> field decode: sign, zero/NaR flags, scale, and the
// mantissa with its hidden bit, left-aligned as 1.29 fixed point.
module posit_field_decode
  import posit_pkg::*;
(
  input  logic [N-1:0]  posit_i,
  output logic          sign_o,
  output logic          zero_o,
  output logic          nar_o,
  output scale_t        scale_o,
  output logic [MW-1:0] frac_o
);

  logic [N-2:0] mag;
  logic [N-2:0] rest;
  logic [5:0]   run;
  logic         run_end;
  scale_t       k;

  assign sign_o = posit_i[N-1];
  assign zero_o = (posit_i == '0);
  assign nar_o  = (posit_i == NAR);

  // NOTE: every variable gets a value before any branch so no latch is inferred.
  always_comb begin
    mag     = (N-1)'(posit_i[N-1] ? -posit_i : posit_i);
    run     = '0;
    run_end = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!run_end && (mag[i] == mag[N-2])) run = run + 6'd1;
      else run_end = 1'b1;
    end
    // Drop the regime run and its terminator; exponent then fraction follow.
    rest    = mag << (run + 6'd1);
    k       = mag[N-2] ? scale_t'({4'd0, run}) - scale_t'(1)
                       : -scale_t'({4'd0, run});
    scale_o = (k <<< ES) + scale_t'(rest[N-2 -: ES]);
    frac_o  = {1'b1, rest[N-2-ES:0], 1'b0};
  end

endmodule

// File: rtl/posit_div.sv
// Sequential posit<32,3> divider: decode, 30-cycle restoring mantissa divide,
// normalise, then round-to-nearest-even re-encode with saturation.
module posit_div #(
  parameter int N  = 32,
  parameter int ES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] posit_a,
  input  logic [N-1:0] posit_b,
  output logic [N-1:0] posit_result,
  output logic         done,
  output logic         busy
);
  import posit_pkg::*;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0]  enc_q, enc_d, result_q, result_d;
  logic          sign_q, sign_d, sticky_q, sticky_d;
  logic          done_q, done_d, busy_q, busy_d;
  scale_t        scale_q, scale_d;
  logic [MW-1:0] mant_b_q, mant_b_d, quo_q, quo_d;
  logic [MW:0]   rem_q, rem_d;
  logic [4:0]    cnt_q, cnt_d;

  logic          sign_a, zero_a, nar_a, sign_b, zero_b, nar_b;
  scale_t        scale_a, scale_b;
  logic [MW-1:0] frac_a, frac_b;

  posit_field_decode u_dec_a (
    .posit_i (a_q),
    .sign_o  (sign_a),
    .zero_o  (zero_a),
    .nar_o   (nar_a),
    .scale_o (scale_a),
    .frac_o  (frac_a)
  );

  posit_field_decode u_dec_b (
    .posit_i (b_q),
    .sign_o  (sign_b),
    .zero_o  (zero_b),
    .nar_o   (nar_b),
    .scale_o (scale_b),
    .frac_o  (frac_b)
  );

  logic [MW:0]      trial;
  logic             q_bit;
  scale_t           k, k_neg;
  logic [6:0]       rlen;
  logic [N-1:0]     tail, mag, enc_word;
  logic [2*N-1:0]   regime_pat, body;
  logic             guard, sticky_all, round_up;

  assign trial = rem_q - {1'b0, mant_b_q};
  assign q_bit = (rem_q >= {1'b0, mant_b_q});

  // Lay out regime, exponent and fraction MSB-first in a double-width word so
  // the kept bits, guard bit and sticky tail fall at fixed positions.
  always_comb begin
    k     = scale_q >>> ES;
    k_neg = -k;
    tail  = {scale_q[ES-1:0], quo_q[MW-2:0]};
    if (k >= 0) begin
      regime_pat = ~({(2*N){1'b1}} >> 7'(k + scale_t'(1)));
      rlen       = 7'(k + scale_t'(2));
    end else begin
      regime_pat = {1'b1, {(2*N-1){1'b0}}} >> 7'(k_neg);
      rlen       = 7'(k_neg + scale_t'(1));
    end
    body       = regime_pat | ({tail, {N{1'b0}}} >> rlen);
    guard      = body[N];
    sticky_all = sticky_q | (|body[N-1:0]);
    round_up   = guard & (body[N+1] | sticky_all);
    mag        = {1'b0, body[2*N-1:N+1]} + {{(N-1){1'b0}}, round_up};
    if (scale_q > SCALE_MAX)       mag = MAXPOS;
    else if (scale_q < -SCALE_MAX) mag = MINPOS;
    else if (mag[N-1])             mag = MAXPOS;
    else if (mag == '0)            mag = MINPOS;
    enc_word = sign_q ? -mag : mag;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    enc_d    = enc_q;
    result_d = result_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    scale_d  = scale_q;
    mant_b_d = mant_b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // The done cycle is still part of the previous operation.
        if (start && !done_q) begin
          a_d     = posit_a;
          b_d     = posit_b;
          busy_d  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        sign_d   = sign_a ^ sign_b;
        scale_d  = scale_a - scale_b;
        rem_d    = {1'b0, frac_a};
        mant_b_d = frac_b;
        quo_d    = '0;
        sticky_d = 1'b0;
        cnt_d    = 5'(MW - 1);
        if (nar_a || nar_b || zero_b) begin
          enc_d   = NAR;
          state_d = DONE;
        end else if (zero_a) begin
          enc_d   = '0;
          state_d = DONE;
        end else begin
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = (q_bit ? trial : rem_q) << 1;
        quo_d = {quo_q[MW-2:0], q_bit};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == '0) state_d = NORM;
      end
      NORM: begin
        sticky_d = (rem_q != '0);
        if (!quo_q[MW-1]) begin
          quo_d   = quo_q << 1;
          scale_d = scale_q - scale_t'(1);
        end
        state_d = ENCODE;
      end
      ENCODE: begin
        enc_d   = enc_word;
        state_d = DONE;
      end
      DONE: begin
        result_d = enc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too, so an aborted divide leaves no residue.
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      enc_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      scale_q  <= '0;
      mant_b_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      enc_q    <= enc_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      scale_q  <= scale_d;
      mant_b_q <= mant_b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  assign posit_result = result_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule
